// File: rtl/cpu_test_ctrl.sv
// cpu_test_ctrl: core reset sequencer, tohost result monitor and cycle watchdog beside the cpu.
// Define CPU_TEST_CTRL_CONSOLE_EN to build the console character FIFO.
module cpu_test_ctrl #(
    parameter int          ADDR_W         = 32,
    parameter int          CYCLE_W        = 32,
    parameter int          RESET_CYCLES   = 4,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_1004,
    parameter int          CON_DEPTH      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  data_addr,
    input  logic [31:0]        write_data,
    input  logic               we,
    output logic               cpu_reset,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [30:0]        fail_code,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               con_valid,
    output logic [7:0]         con_data,
    input  logic               con_ready,
    output logic               con_overflow
);
    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;
    localparam int HW = $clog2(RESET_CYCLES + 1);
    state_t             state_q;
    logic [HW-1:0]      hold_q;
    logic               cpu_reset_q, done_q, pass_q, timeout_q;
    logic [30:0]        fail_code_q;
    logic [CYCLE_W-1:0] cycle_q;
    logic               tohost_hit, to_hit;
    assign tohost_hit = state_q == RUN && we && data_addr == ADDR_W'(TOHOST_ADDR) && write_data[0];
    assign to_hit = TIMEOUT_CYCLES != 0 && cycle_q == CYCLE_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HOLD;
            hold_q      <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code_q <= '0;
            cycle_q     <= '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (hold_q == HW'(RESET_CYCLES - 1)) begin
                        state_q     <= RUN;
                        cpu_reset_q <= 1'b0;
                    end else hold_q <= hold_q + 1'b1;
                end
                RUN: begin
                    // a result store takes priority over a simultaneous watchdog expiry
                    if (tohost_hit) begin
                        state_q     <= DONE;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b1;
                        pass_q      <= write_data == 32'd1;
                        fail_code_q <= write_data[31:1];
                    end else if (to_hit) begin
                        state_q     <= DONE;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b1;
                        timeout_q   <= 1'b1;
                    end else if (cycle_q != '1) cycle_q <= cycle_q + 1'b1;
                end
                default: ;
            endcase
        end
    end
    assign cpu_reset   = cpu_reset_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_q;
`ifdef CPU_TEST_CTRL_CONSOLE_EN
    localparam int AW = $clog2(CON_DEPTH);
    logic [7:0]  mem_q [CON_DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        valid_q, valid_d, ovf_q, ovf_d, pop, push_req, push, full;
    logic [7:0]  data_q, data_d;
    always_comb begin
        pop      = valid_q & con_ready;
        push_req = state_q == RUN && we && data_addr == ADDR_W'(CONSOLE_ADDR);
        full     = cnt_q == (AW+1)'(CON_DEPTH);
        push     = push_req && (!full || pop);
        rd_d     = rd_q + AW'(pop);
        wr_d     = wr_q + AW'(push);
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        valid_d  = cnt_d != '0;
        ovf_d    = ovf_q | (push_req & full & ~pop);
        // when the FIFO drains to empty this cycle, the incoming byte becomes the head directly
        data_d   = cnt_q == (AW+1)'(pop) ? write_data[7:0] : mem_q[rd_d];
    end
    always_ff @(posedge clk) if (push) mem_q[wr_q] <= write_data[7:0];
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
        end
    end
    assign con_valid    = valid_q;
    assign con_data     = data_q;
    assign con_overflow = ovf_q;
`else
    logic unused_con;
    assign unused_con   = con_ready;
    assign con_valid    = 1'b0;
    assign con_data     = 8'h00;
    assign con_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_test_ctrl.sv
// tb_cpu_test_ctrl: directed bench for cpu_test_ctrl with a console byte scoreboard.
module tb_cpu_test_ctrl;
    logic        clk = 1'b0, reset = 1'b1, we = 1'b0, con_ready = 1'b0;
    logic [31:0] data_addr = '0, write_data = '0;
    logic        cpu_reset, done, pass, timeout, con_valid, con_overflow;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic [7:0]  con_data;
    int          checks = 0, errors = 0;
    logic [7:0]  exp_q [$];

    cpu_test_ctrl #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(50), .CON_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .data_addr(data_addr), .write_data(write_data), .we(we),
        .cpu_reset(cpu_reset), .done(done), .pass(pass), .timeout(timeout), .fail_code(fail_code),
        .cycle_count(cycle_count), .con_valid(con_valid), .con_data(con_data),
        .con_ready(con_ready), .con_overflow(con_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        data_addr = a;
        write_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        we = 1'b0;
        tick();
        tick();
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 1);
        chk("rst_status", {28'd0, done, pass, timeout, con_overflow}, 0);
        chk("rst_fail_code", {1'b0, fail_code}, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_con_valid", {31'd0, con_valid}, 0);
    endtask

    // cpu_reset must stay high for exactly four cycles after reset falls
    task automatic release_reset();
        reset = 1'b0;
        chk("hold0", {31'd0, cpu_reset}, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("hold%0d", i), {31'd0, cpu_reset}, 1);
        end
        tick();
        chk("run_cpu_reset", {31'd0, cpu_reset}, 0);
        chk("run_cycle0", cycle_count, 0);
    endtask

    initial begin
        // fail result, ignored even value and near-miss address
        apply_reset();
        release_reset();
        store(32'h1000, 32'h2);
        chk("even_ignored", {31'd0, done}, 0);
        chk("even_cycle", cycle_count, 1);
        store(32'h1001, 32'h1);
        chk("addr_mismatch", {31'd0, done}, 0);
        store(32'h1000, 32'h7);
        chk("fail_done", {29'd0, done, pass, timeout}, 32'b100);
        chk("fail_code", {1'b0, fail_code}, 3);
        chk("fail_cpu_reset", {31'd0, cpu_reset}, 1);
        chk("fail_cycle", cycle_count, 2);
        repeat (5) tick();
        store(32'h1000, 32'h1);
        chk("done_frozen", cycle_count, 2);
        chk("done_sticky", {29'd0, done, pass, timeout}, 32'b100);

        // pass result
        apply_reset();
        release_reset();
        repeat (3) tick();
        store(32'h1000, 32'h1);
        chk("pass_status", {29'd0, done, pass, timeout}, 32'b110);
        chk("pass_cpu_reset", {31'd0, cpu_reset}, 1);
        chk("pass_fail_code", {1'b0, fail_code}, 0);
        chk("pass_cycle", cycle_count, 3);
        tick();
        chk("pass_frozen", cycle_count, 3);

        // watchdog expiry
        apply_reset();
        release_reset();
        repeat (49) tick();
        chk("pre_timeout", {30'd0, done, timeout}, 0);
        chk("pre_timeout_cycle", cycle_count, 49);
        tick();
        chk("timeout_status", {29'd0, done, pass, timeout}, 32'b101);
        chk("timeout_cycle", cycle_count, 49);
        chk("timeout_cpu_reset", {31'd0, cpu_reset}, 1);

        // result store in the expiry cycle wins over the watchdog
        apply_reset();
        release_reset();
        repeat (49) tick();
        store(32'h1000, 32'h1);
        chk("tie_status", {29'd0, done, pass, timeout}, 32'b110);

        // mid-run reset
        apply_reset();
        release_reset();
        store(32'h1004, 32'h5a);
        repeat (19) tick();
        chk("midrun_cycle", cycle_count, 20);
        apply_reset();
        release_reset();

`ifdef CPU_TEST_CTRL_CONSOLE_EN
        // console FIFO fill, overflow and ordered drain
        apply_reset();
        release_reset();
        con_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() < 4) exp_q.push_back(8'h41 + 8'(i));
            store(32'h1004, 32'h41 + i);
            if (i == 0) chk("con_first_valid", {23'd0, con_valid, con_data}, 32'h141);
        end
        chk("con_overflow", {31'd0, con_overflow}, 1);
        con_ready = 1'b1;
        for (int n = 0; n < 12 && exp_q.size() != 0; n++) begin
            if (con_valid) chk("con_byte", {24'd0, con_data}, {24'd0, exp_q.pop_front()});
            tick();
        end
        chk("con_drained", exp_q.size(), 0);
        chk("con_empty", {31'd0, con_valid}, 0);
        apply_reset();
`else
        // without the console build, console stores leave nothing behind
        apply_reset();
        release_reset();
        con_ready = 1'b1;
        store(32'h1004, 32'h41);
        chk("con_tied", {22'd0, con_valid, con_overflow, con_data}, 0);
        chk("con_store_not_result", {31'd0, done}, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
